// File: rtl/frame_pixel_packer.sv
// Packs a byte-serial pixel stream into DATA_WIDTH words for the frame buffer.
// Emits one active-low write strobe per packed word, WORDS_PER_FRAME per frame.
module frame_pixel_packer #(
   parameter int PIX_WIDTH       = 8,
   parameter int DATA_WIDTH      = 32,
   parameter int WORDS_PER_FRAME = 8,
   parameter int PIX_PER_WORD    = DATA_WIDTH / PIX_WIDTH,
   localparam int CW = $clog2(WORDS_PER_FRAME + 1),
   localparam int IW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1
) (
   input  logic                  wr_clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  pix_valid,
   input  logic [PIX_WIDTH-1:0]  pix_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  wr_en_out,
   output logic                  frame_done,
   output logic [CW-1:0]         word_cnt,
   output logic                  short_frame,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DONE
   } state_t;

   state_t                state;
   logic [IW-1:0]         pix_idx;
   logic [DATA_WIDTH-1:0] shreg;

   logic                  accept;
   logic [IW-1:0]         idx_base;
   logic [CW-1:0]         cnt_base;
   logic [DATA_WIDTH-1:0] asm_word;
   logic                  last_pix;
   logic                  last_word;

   // A frame_start restarts packing, so the same-cycle pixel lands in lane 0.
   always_comb begin
      accept   = pix_valid && (frame_start || state == CAPTURE);
      idx_base = frame_start ? '0 : pix_idx;
      cnt_base = frame_start ? '0 : word_cnt;
      asm_word = frame_start ? '0 : shreg;
      asm_word[int'(idx_base)*PIX_WIDTH +: PIX_WIDTH] = pix_data;
      last_pix  = accept && (int'(idx_base) == PIX_PER_WORD - 1);
      last_word = last_pix
               && (int'(cnt_base) == WORDS_PER_FRAME - 1);
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state       <= IDLE;
         pix_idx     <= '0;
         shreg       <= '0;
         data_out    <= '0;
         wr_en_out   <= 1'b1;
         frame_done  <= 1'b0;
         word_cnt    <= '0;
         short_frame <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         wr_en_out  <= 1'b1;
         frame_done <= 1'b0;

         if (frame_start) begin
            state    <= CAPTURE;
            pix_idx  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            if (state == CAPTURE)
               short_frame <= 1'b1;
         end else if (state == DONE && pix_valid) begin
            overrun <= 1'b1;
         end

         if (accept) begin
            shreg <= asm_word;
            if (last_pix) begin
               data_out  <= asm_word;
               wr_en_out <= 1'b0;
               word_cnt  <= cnt_base + CW'(1);
               pix_idx   <= '0;
               if (last_word) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end else begin
               pix_idx <= idx_base + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_pixel_packer.sv
// Randomized self-checking bench for frame_pixel_packer.
// Expected words come from a pixel-list model of the frame.
module tb_frame_pixel_packer;

   typedef logic [7:0] pq_t[$];

   logic        wr_clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_data = '0;
   logic [31:0] data_out;
   logic        wr_en_out;
   logic        frame_done;
   logic [3:0]  word_cnt;
   logic        short_frame;
   logic        overrun;

   int pass_n = 0;
   int total_n = 0;
   int cyc_n = 0;

   logic [31:0] got[$];
   int          got_cyc[$];
   logic [31:0] ref_q[$];
   int          fd_cnt, fd_bad, consec;
   logic        prev_low = 1'b0;

   frame_pixel_packer dut (
      .wr_clk(wr_clk),
      .reset(reset),
      .frame_start(frame_start),
      .pix_valid(pix_valid),
      .pix_data(pix_data),
      .data_out(data_out),
      .wr_en_out(wr_en_out),
      .frame_done(frame_done),
      .word_cnt(word_cnt),
      .short_frame(short_frame),
      .overrun(overrun)
   );

   always #5 wr_clk = ~wr_clk;

   always @(posedge wr_clk) cyc_n++;

   always @(negedge wr_clk) begin
      if (wr_en_out === 1'b0) begin
         got.push_back(data_out);
         got_cyc.push_back(cyc_n);
      end
      if (frame_done === 1'b1) begin
         fd_cnt++;
         if (wr_en_out !== 1'b0) fd_bad++;
      end
      if (wr_en_out === 1'b0 && prev_low) consec++;
      prev_low = (wr_en_out === 1'b0);
   end

   task automatic cyc(input logic fs, input logic pv,
                      input logic [7:0] pd);
      frame_start = fs;
      pix_valid   = pv;
      pix_data    = pd;
      @(negedge wr_clk);
   endtask

   task automatic clr();
      got.delete();
      got_cyc.delete();
      ref_q.delete();
      fd_cnt = 0;
      fd_bad = 0;
      consec = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      reset = 1'b0;
      clr();
   endtask

   // One word per four consecutive pixels, first pixel in the LSBs,
   // at most eight words per frame; trailing partial words vanish.
   task automatic model_frame(input pq_t px);
      for (int w = 0; w < 8 && 4*w+3 < px.size(); w++)
         ref_q.push_back({px[4*w+3], px[4*w+2], px[4*w+1], px[4*w]});
   endtask

   task automatic check_words(input string name);
      logic bad;
      total_n++;
      bad = (got.size() != ref_q.size());
      foreach (ref_q[i])
         if (i < got.size() && got[i] !== ref_q[i]) bad = 1'b1;
      if (bad)
         $display("FAIL %s: got %0d words (w0=%h), required %0d (w0=%h)",
                  name, got.size(), got.size() ? got[0] : 32'h0,
                  ref_q.size(), ref_q.size() ? ref_q[0] : 32'h0);
      else pass_n++;
   endtask

   task automatic test_reset();
      do_reset();
      total_n++;
      if ({wr_en_out, frame_done, short_frame, overrun} !== 4'b1000) begin
         $display("FAIL reset_flags: got %b required 1000",
                  {wr_en_out, frame_done, short_frame, overrun});
      end else pass_n++;
      total_n++;
      if (data_out !== 32'h0 || word_cnt !== 4'd0)
         $display("FAIL reset_data: got %h/%0d required 0/0",
                  data_out, word_cnt);
      else pass_n++;
      for (int i = 0; i < 6; i++) cyc(0, 1, 8'($urandom));
      total_n++;
      if (got.size() != 0)
         $display("FAIL idle_ignore: got %0d strobes required 0",
                  got.size());
      else pass_n++;
   endtask

   task automatic test_full_frame();
      pq_t px;
      do_reset();
      cyc(1, 0, 0);
      for (int i = 0; i < 32; i++) begin
         px.push_back(8'(i));
         cyc(0, 1, 8'(i));
      end
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      model_frame(px);
      total_n++;
      if (got.size() != 8)
         $display("FAIL full_count: got %0d required 8", got.size());
      else pass_n++;
      total_n++;
      if (got[0] !== 32'h03020100 || got[7] !== 32'h1F1E1D1C)
         $display("FAIL full_ends: got %h/%h required 03020100/1f1e1d1c",
                  got[0], got[7]);
      else pass_n++;
      check_words("full_words");
      total_n++;
      begin
         int bad = 0;
         for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 4) bad++;
         if (bad != 0)
            $display("FAIL full_spacing: got %0d bad gaps required 0", bad);
         else pass_n++;
      end
      total_n++;
      if (fd_cnt != 1 || fd_bad != 0)
         $display("FAIL full_done: got %0d pulses (%0d stray) required 1",
                  fd_cnt, fd_bad);
      else pass_n++;
      total_n++;
      if (word_cnt !== 4'd8 || short_frame !== 1'b0 || overrun !== 1'b0)
         $display("FAIL full_state: got cnt %0d s %b o %b required 8 0 0",
                  word_cnt, short_frame, overrun);
      else pass_n++;
   endtask

   task automatic test_toggle();
      pq_t px;
      do_reset();
      cyc(1, 0, 0);
      for (int i = 0; i < 32; i++) begin
         px.push_back(8'($urandom));
         cyc(0, 1, px[i]);
         cyc(0, 0, 8'($urandom));
      end
      cyc(0, 0, 0);
      model_frame(px);
      check_words("toggle_words");
      total_n++;
      begin
         int bad = 0;
         for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 8) bad++;
         if (bad != 0 || got_cyc.size() != 8)
            $display("FAIL toggle_spacing: got %0d bad of %0d required 0 of 8",
                     bad, got_cyc.size());
         else pass_n++;
      end
   endtask

   task automatic test_random_gaps();
      pq_t px;
      do_reset();
      cyc(1, 0, 0);
      for (int i = 0; i < 32; i++) begin
         int g = $urandom_range(0, 3);
         for (int k = 0; k < g; k++) cyc(0, 0, 8'($urandom));
         px.push_back(8'($urandom));
         cyc(0, 1, px[i]);
      end
      cyc(0, 0, 0);
      model_frame(px);
      check_words("gap_words");
      total_n++;
      if (consec != 0 || fd_cnt != 1 || word_cnt !== 4'd8)
         $display("FAIL gap_state: got consec %0d fd %0d cnt %0d required 0 1 8",
                  consec, fd_cnt, word_cnt);
      else pass_n++;
   endtask

   task automatic test_overrun();
      pq_t px;
      do_reset();
      px.push_back(8'hAA);
      cyc(1, 1, 8'hAA);
      for (int i = 1; i < 36; i++) begin
         px.push_back(8'($urandom));
         cyc(0, 1, px[i]);
      end
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      model_frame(px);
      check_words("ovr_words");
      total_n++;
      if (got[0][7:0] !== 8'hAA)
         $display("FAIL ovr_first: got %h required aa", got[0][7:0]);
      else pass_n++;
      total_n++;
      if (got.size() != 8 || overrun !== 1'b1 || short_frame !== 1'b0)
         $display("FAIL ovr_flags: got %0d strobes o %b s %b required 8 1 0",
                  got.size(), overrun, short_frame);
      else pass_n++;
   endtask

   task automatic test_short_frame();
      pq_t a, b;
      do_reset();
      cyc(1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         a.push_back(8'(i));
         cyc(0, 1, 8'(i));
      end
      cyc(1, 0, 0);
      for (int i = 0; i < 32; i++) begin
         b.push_back(8'(8'h40 + i));
         cyc(0, 1, 8'(8'h40 + i));
      end
      cyc(0, 0, 0);
      model_frame(a);
      model_frame(b);
      check_words("short_words");
      total_n++;
      if (got.size() != 10 || got[2] !== 32'h43424140)
         $display("FAIL short_next: got %0d strobes w2 %h required 10 43424140",
                  got.size(), got[2]);
      else pass_n++;
      total_n++;
      if (short_frame !== 1'b1 || overrun !== 1'b0 || fd_cnt != 1)
         $display("FAIL short_flags: got s %b o %b fd %0d required 1 0 1",
                  short_frame, overrun, fd_cnt);
      else pass_n++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(1, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 8'($urandom));
      reset = 1'b1;
      cyc(0, 0, 0);
      total_n++;
      if (wr_en_out !== 1'b1 || word_cnt !== 4'd0 || data_out !== 32'h0)
         $display("FAIL mid_reset: got we %b cnt %0d d %h required 1 0 0",
                  wr_en_out, word_cnt, data_out);
      else pass_n++;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) cyc(0, 1, 8'($urandom));
      cyc(0, 0, 0);
      total_n++;
      if (got.size() != 1 || word_cnt !== 4'd0)
         $display("FAIL mid_after: got %0d strobes cnt %0d required 1 0",
                  got.size(), word_cnt);
      else pass_n++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int f = 0; f < 2; f++) begin
         pq_t px;
         cyc(1, 0, 0);
         total_n++;
         if (word_cnt !== 4'd0)
            $display("FAIL b2b_restart%0d: got %0d required 0", f, word_cnt);
         else pass_n++;
         for (int i = 0; i < 32; i++) begin
            px.push_back(8'($urandom));
            cyc(0, 1, px[i]);
         end
         model_frame(px);
         cyc(0, 0, 0);
      end
      cyc(0, 0, 0);
      check_words("b2b_words");
      total_n++;
      if (got.size() != 16 || fd_cnt != 2 || fd_bad != 0 || consec != 0)
         $display("FAIL b2b_state: got %0d strobes fd %0d/%0d consec %0d required 16 2/0 0",
                  got.size(), fd_cnt, fd_bad, consec);
      else pass_n++;
      total_n++;
      if (word_cnt !== 4'd8 || short_frame !== 1'b0)
         $display("FAIL b2b_end: got cnt %0d s %b required 8 0",
                  word_cnt, short_frame);
      else pass_n++;
   endtask

   initial begin
      @(negedge wr_clk);
      test_reset();
      test_full_frame();
      test_toggle();
      test_random_gaps();
      test_overrun();
      test_short_frame();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule

// File: doc/frame_pixel_packer.md
# frame_pixel_packer

Upstream feeder for the frame buffer: accepts a byte-serial pixel stream from the capture front end, packs PIX_PER_WORD pixels into one DATA_WIDTH word, and emits exactly WORDS_PER_FRAME words per frame. Each word is presented on data_out with a single-cycle active-low write strobe, so the frame buffer fills addresses 0..WORDS_PER_FRAME-1 in order. Framing errors (short frames, excess pixels) are flagged and never produce extra writes.

## Interface
- PIX_WIDTH, 8, bits per pixel
- DATA_WIDTH, 32, output word width; must be an integer multiple of PIX_WIDTH
- WORDS_PER_FRAME, 8, words written per frame (frame buffer depth)
- PIX_PER_WORD, DATA_WIDTH/PIX_WIDTH, derived; not to be overridden

- wr_clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse marking the start of a frame
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  PIX_WIDTH  pixel value
- data_out  out  DATA_WIDTH  packed word; to frame buffer data_in
- wr_en_out  out  1  active-low write strobe; to frame buffer wr_en_in
- frame_done  out  1  one-cycle pulse after the last word of a frame is written
- word_cnt  out  clog2(WORDS_PER_FRAME+1)  words written in current frame
- short_frame  out  1  sticky: frame_start arrived before frame complete
- overrun  out  1  sticky: pix_valid seen while in DONE

## Operation
- Reset: state IDLE, data_out 0, wr_en_out 1, frame_done 0, word_cnt 0, short_frame 0, overrun 0, pixel index 0, shift register 0.
- States: IDLE, CAPTURE, DONE.
- IDLE: pix_valid ignored. frame_start -> CAPTURE; if pix_valid in the same cycle, that pixel is pixel 0.
- CAPTURE: each pix_valid stores pix_data into lane pix_idx (lane 0 = bits PIX_WIDTH-1:0, first pixel in LSBs); pix_idx increments. On the PIX_PER_WORD-th pixel: next cycle data_out = assembled word, wr_en_out = 0 for one cycle, word_cnt +1, pix_idx -> 0.
- Word WORDS_PER_FRAME-1 written -> DONE; frame_done pulses in the same cycle as that word's strobe.
- DONE: pixels dropped; any pix_valid sets overrun. frame_start -> CAPTURE, word_cnt 0, pix_idx 0 (same-cycle pixel accepted as pixel 0).
- frame_start in CAPTURE: sets short_frame; partial word discarded (no write); word_cnt 0, pix_idx 0; stays in CAPTURE; same-cycle pixel accepted as pixel 0 of the new frame. Words already written are not retracted.
- frame_start has priority over all other events in the same cycle.
- word_cnt holds WORDS_PER_FRAME in DONE until the next frame_start.
- data_out holds the last written word between strobes.
- short_frame/overrun clear only on reset.

## Timing
- Latency: last pixel of a word accepted on edge N -> wr_en_out low and data_out valid for cycle N+1 only.
- Maximum throughput: 1 pixel/cycle; strobes then spaced exactly PIX_PER_WORD cycles apart, never back-to-back when PIX_PER_WORD > 1.
- wr_en_out never low for two consecutive cycles; at most WORDS_PER_FRAME strobes per frame_start.
- Reset asserted mid-frame: next cycle all outputs at reset values; no strobe issued for the partial word.
- pix_valid gaps of any length in CAPTURE allowed; the packing position is held.

## Test plan
- Reset, frame_start, then 32 consecutive pixels 0x00..0x1F -> 8 strobes, first word 0x03020100, last 0x1F1E1D1C, frame_done with the 8th strobe, word_cnt 8, no flags.
- Same frame with pix_valid toggling every other cycle -> identical 8 words, strobes 8 cycles apart, no strobe while frame_start absent.
- frame_start with pix_valid same cycle, pixel 0xAA -> first word LSB byte 0xAA; 36 pixels total -> 8 strobes, overrun=1, no 9th strobe.
- 10 pixels, then frame_start, then 32 pixels 0x40.. -> 2 strobes, short_frame=1, next 8 words start 0x43424140, partial bytes 0x08,0x09 never written.
- Reset asserted after 6 pixels (1 strobe) -> wr_en_out=1, word_cnt=0, state IDLE; pixels without frame_start produce no strobes.
- Two full frames back-to-back (frame_start the cycle after frame_done) -> 16 strobes total, word_cnt restarts at 0, frame_done twice.
